// File: rtl/mcd212_pkg.sv
// rtl/mcd212_pkg.sv - shared types for the MCD212 system DRAM arbiter
package mcd212_pkg;

    localparam int RAM_AW = 19;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_ICA  = 2'd2,
        OWN_CPU  = 2'd3
    } ram_owner_e;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_ACK
    } ram_arb_state_e;

    typedef struct packed {
        logic              we;
        logic [1:0]        be;
        logic [RAM_AW-1:0] addr;
        logic [15:0]       wdata;
    } ram_cmd_t;

endpackage

// File: rtl/mcd212_dram_arbiter.sv
// rtl/mcd212_dram_arbiter.sv - vid/ica/cpu arbiter and sequencer for the single-port system DRAM
module mcd212_dram_arbiter
    import mcd212_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int CPU_STARVE = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              vid_req_i,
    input  logic [RAM_AW-1:0] vid_addr_i,
    output logic              vid_ack_o,
    input  logic              ica_req_i,
    input  logic [RAM_AW-1:0] ica_addr_i,
    output logic              ica_ack_o,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [1:0]        cpu_be_i,
    input  logic [RAM_AW-1:0] cpu_addr_i,
    input  logic [15:0]       cpu_wdata_i,
    output logic              cpu_ack_o,
    output logic [15:0]       rdata_o,
    output logic [1:0]        grant_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [1:0]        ram_be_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic [15:0]       ram_wdata_o,
    input  logic [15:0]       ram_rdata_i
);

    localparam logic [7:0] STARVE_MAX = 8'(CPU_STARVE);
    localparam logic [1:0] WAIT_LAST  = 2'(RD_LATENCY - 2);

    ram_arb_state_e state_q, state_d;
    ram_owner_e     owner_q, win_d;
    ram_cmd_t       cmd_q, cmd_d;
    logic [7:0]     starve_q;
    logic [1:0]     wait_q;
    logic           cpu_owns;

    always_comb begin
        win_d = OWN_NONE;
        if (cpu_req_i && starve_q == STARVE_MAX) win_d = OWN_CPU;
        else if (vid_req_i)                      win_d = OWN_VID;
        else if (ica_req_i)                      win_d = OWN_ICA;
        else if (cpu_req_i)                      win_d = OWN_CPU;
    end

    // wdata only changes on a CPU write so ram_wdata_o holds across reads
    always_comb begin
        cmd_d = cmd_q;
        case (win_d)
            OWN_VID: cmd_d = '{we: 1'b0, be: 2'b11, addr: vid_addr_i, wdata: cmd_q.wdata};
            OWN_ICA: cmd_d = '{we: 1'b0, be: 2'b11, addr: ica_addr_i, wdata: cmd_q.wdata};
            OWN_CPU: begin
                cmd_d.we   = cpu_we_i;
                cmd_d.be   = cpu_we_i ? cpu_be_i : 2'b11;
                cmd_d.addr = cpu_addr_i;
                if (cpu_we_i) cmd_d.wdata = cpu_wdata_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= ARB_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:  if (win_d != OWN_NONE) state_d = ARB_ISSUE;
            ARB_ISSUE: begin
                if (cmd_q.we)             state_d = ARB_IDLE;
                else if (RD_LATENCY == 1) state_d = ARB_ACK;
                else                      state_d = ARB_WAIT;
            end
            ARB_WAIT:  if (wait_q == WAIT_LAST) state_d = ARB_ACK;
            ARB_ACK:   state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    assign cpu_owns = (state_q != ARB_IDLE) && (owner_q == OWN_CPU);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            owner_q  <= OWN_NONE;
            cmd_q    <= '0;
            starve_q <= '0;
            wait_q   <= '0;
        end else begin
            if (state_q == ARB_IDLE && win_d != OWN_NONE) begin
                owner_q <= win_d;
                cmd_q   <= cmd_d;
            end
            if (state_q == ARB_ISSUE)     wait_q <= '0;
            else if (state_q == ARB_WAIT) wait_q <= wait_q + 2'd1;
            if (state_q == ARB_IDLE && win_d == OWN_CPU)
                starve_q <= '0;
            else if (cpu_req_i && !cpu_owns && starve_q < STARVE_MAX)
                starve_q <= starve_q + 8'd1;
        end
    end

    always_comb begin
        logic ack_any;
        ack_any     = (state_q == ARB_ACK) || (state_q == ARB_ISSUE && cmd_q.we);
        vid_ack_o   = ack_any && owner_q == OWN_VID;
        ica_ack_o   = ack_any && owner_q == OWN_ICA;
        cpu_ack_o   = ack_any && owner_q == OWN_CPU;
        rdata_o     = (state_q == ARB_ACK) ? ram_rdata_i : 16'h0000;
        grant_o     = (state_q == ARB_IDLE) ? OWN_NONE : owner_q;
        ram_en_o    = (state_q == ARB_ISSUE);
        ram_we_o    = (state_q == ARB_ISSUE) && cmd_q.we;
        ram_be_o    = (state_q == ARB_ISSUE) ? cmd_q.be : 2'b00;
        ram_addr_o  = (state_q == ARB_ISSUE) ? cmd_q.addr : '0;
        ram_wdata_o = cmd_q.wdata;
    end

endmodule
